// File: rtl/window_trap_sequencer.sv
// Register-window SAVE/RESTORE sequencer: drives the window trap generator, commits CWP,
// or performs window_overflow/window_underflow trap entry (PSR, CWP, r17/r18, TBR, redirect).
module window_trap_sequencer #(
   parameter int NWINDOWS = 4,
   parameter int CWP_W    = 5
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             save_req,
   input  logic             restore_req,
   input  logic             overFlow,
   input  logic             underFlow,
   input  logic [31:0]      pc_in,
   input  logic [31:0]      npc_in,
   input  logic [19:0]      tba_in,
   output logic             tg_enable,
   output logic             tg_bitDir,
   output logic [CWP_W-1:0] cwp,
   output logic             psr_et,
   output logic             psr_s,
   output logic             psr_ps,
   output logic [31:0]      tbr_out,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             pc_load,
   output logic [31:0]      pc_new,
   output logic             busy,
   output logic             done,
   output logic             error_mode
);

   typedef enum logic [3:0] {
      IDLE, CHECK, EVAL, COMMIT, TRAP_PSR, SAVE_PC, SAVE_NPC, REDIRECT, ERROR
   } state_t;

   state_t      state;
   logic        dir;
   logic [7:0]  tt;
   logic [31:0] pc_q;
   logic [31:0] npc_q;

   function automatic logic [CWP_W-1:0] cwp_inc(input logic [CWP_W-1:0] c);
      if (c == CWP_W'(NWINDOWS - 1)) return '0;
      return c + CWP_W'(1);
   endfunction

   function automatic logic [CWP_W-1:0] cwp_dec(input logic [CWP_W-1:0] c);
      if (c == '0) return CWP_W'(NWINDOWS - 1);
      return c - CWP_W'(1);
   endfunction

   assign tg_bitDir = dir;
   assign tbr_out   = {tba_in, tt, 4'b0000};
   assign busy      = (state != IDLE) && (state != ERROR);

   // Outputs are registered: each state's strobes are set on the edge that enters it.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         state      <= IDLE;
         dir        <= 1'b0;
         tt         <= 8'h00;
         pc_q       <= '0;
         npc_q      <= '0;
         cwp        <= '0;
         psr_et     <= 1'b1;
         psr_s      <= 1'b1;
         psr_ps     <= 1'b0;
         tg_enable  <= 1'b0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         pc_load    <= 1'b0;
         pc_new     <= '0;
         done       <= 1'b0;
         error_mode <= 1'b0;
      end else begin
         tg_enable <= 1'b0;
         rf_we     <= 1'b0;
         pc_load   <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (save_req || restore_req) begin
                  dir       <= save_req;
                  pc_q      <= pc_in;
                  npc_q     <= npc_in;
                  tg_enable <= 1'b1;
                  state     <= CHECK;
               end
            end
            CHECK: state <= EVAL;
            EVAL: begin
               if (overFlow || underFlow) begin
                  if (!psr_et) begin
                     error_mode <= 1'b1;
                     state      <= ERROR;
                  end else begin
                     psr_ps <= psr_s;
                     psr_s  <= 1'b1;
                     psr_et <= 1'b0;
                     cwp    <= cwp_inc(cwp);
                     tt     <= overFlow ? 8'h05 : 8'h06;
                     state  <= TRAP_PSR;
                  end
               end else begin
                  cwp   <= dir ? cwp_inc(cwp) : cwp_dec(cwp);
                  done  <= 1'b1;
                  state <= COMMIT;
               end
            end
            COMMIT: state <= IDLE;
            // r17/r18 land in the new window selected during TRAP_PSR.
            TRAP_PSR: begin
               rf_we    <= 1'b1;
               rf_waddr <= 5'd17;
               rf_wdata <= pc_q;
               state    <= SAVE_PC;
            end
            SAVE_PC: begin
               rf_we    <= 1'b1;
               rf_waddr <= 5'd18;
               rf_wdata <= npc_q;
               state    <= SAVE_NPC;
            end
            SAVE_NPC: begin
               pc_load <= 1'b1;
               pc_new  <= tbr_out;
               done    <= 1'b1;
               state   <= REDIRECT;
            end
            REDIRECT: state <= IDLE;
            ERROR:    state <= ERROR;
            default:  state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_window_trap_sequencer.sv
// Bench for window_trap_sequencer: directed vector table, hand-written reset-abort sequence,
// and randomized transactions checked against an event-level reference model.
module tb_window_trap_sequencer;

   logic        Clk = 1'b0;
   logic        Clr = 1'b1;
   logic        save_req = 1'b0, restore_req = 1'b0, overFlow = 1'b0, underFlow = 1'b0;
   logic [31:0] pc_in = '0, npc_in = '0;
   logic [19:0] tba_in = '0;
   logic        tg_enable, tg_bitDir, psr_et, psr_s, psr_ps, rf_we, pc_load, busy, done, error_mode;
   logic [4:0]  cwp, rf_waddr;
   logic [31:0] tbr_out, rf_wdata, pc_new;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   int   m_cwp;
   logic m_et, m_s, m_ps, m_err;
   logic [7:0] m_tt;

   window_trap_sequencer #(.NWINDOWS(4), .CWP_W(5)) dut (
      .Clk(Clk), .Clr(Clr), .save_req(save_req), .restore_req(restore_req),
      .overFlow(overFlow), .underFlow(underFlow), .pc_in(pc_in), .npc_in(npc_in),
      .tba_in(tba_in), .tg_enable(tg_enable), .tg_bitDir(tg_bitDir), .cwp(cwp),
      .psr_et(psr_et), .psr_s(psr_s), .psr_ps(psr_ps), .tbr_out(tbr_out),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_load(pc_load),
      .pc_new(pc_new), .busy(busy), .done(done), .error_mode(error_mode)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst_first;
      logic        sv, rs, of, uf;
      logic [31:0] pc, npc;
      logic [19:0] tba;
      int          kind;      // 0 commit, 1 trap entry, 2 error entry, 3 ignored (in ERROR)
      logic [4:0]  e_cwp;
      logic        e_et, e_s, e_ps;
      logic [31:0] e_pcnew;
   } vec_t;

   vec_t vt[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cwp = 0; m_et = 1'b1; m_s = 1'b1; m_ps = 1'b0; m_err = 1'b0; m_tt = 8'h00;
   endtask

   task automatic do_reset();
      Clr = 1'b1;
      @(posedge Clk); #1;
      Clr = 1'b0;
      model_reset();
   endtask

   // Issue one request at the current (post-edge) point and watch 8 cycles of outputs.
   task automatic run_txn(input logic sv, input logic rs, input logic of, input logic uf,
                          input logic [31:0] pc, input logic [31:0] npc, input logic [19:0] tba,
                          input int kind, input logic [4:0] e_cwp, input logic e_et,
                          input logic e_s, input logic e_ps, input logic [31:0] e_pcnew);
      int done_c;
      logic exp_busy, exp_err, exp_we, exp_pl;
      done_c = (kind == 0) ? 3 : (kind == 1) ? 6 : 0;
      save_req = sv; restore_req = rs; overFlow = of; underFlow = uf;
      pc_in = pc; npc_in = npc; tba_in = tba;
      for (int c = 1; c <= 8; c++) begin
         @(posedge Clk); #1;
         if (c == 1) begin
            save_req = 1'b0; restore_req = 1'b0;
         end
         check("tg_enable", 32'(tg_enable), 32'(kind != 3 && c == 1));
         if (c == 1 && kind != 3) check("tg_bitDir", 32'(tg_bitDir), 32'(sv));
         exp_we = (kind == 1) && (c == 4 || c == 5);
         check("rf_we", 32'(rf_we), 32'(exp_we));
         if (exp_we) begin
            check("rf_waddr", 32'(rf_waddr), (c == 4) ? 32'd17 : 32'd18);
            check("rf_wdata", rf_wdata, (c == 4) ? pc : npc);
         end
         exp_pl = (kind == 1) && (c == 6);
         check("pc_load", 32'(pc_load), 32'(exp_pl));
         if (exp_pl) check("pc_new", pc_new, e_pcnew);
         check("done", 32'(done), 32'(done_c != 0 && c == done_c));
         case (kind)
            0: exp_busy = (c <= 3);
            1: exp_busy = (c <= 6);
            2: exp_busy = (c <= 2);
            default: exp_busy = 1'b0;
         endcase
         check("busy", 32'(busy), 32'(exp_busy));
         exp_err = (kind == 3) || (kind == 2 && c >= 3);
         check("error_mode", 32'(error_mode), 32'(exp_err));
      end
      check("cwp", 32'(cwp), 32'(e_cwp));
      check("psr_et", 32'(psr_et), 32'(e_et));
      check("psr_s", 32'(psr_s), 32'(e_s));
      check("psr_ps", 32'(psr_ps), 32'(e_ps));
      if (kind == 1) check("tbr_out", tbr_out, e_pcnew);
      overFlow = 1'b0; underFlow = 1'b0;
   endtask

   // Reference model: applies one request's architectural effect and classifies it.
   task automatic model_txn(input logic sv, input logic rs, input logic of, input logic uf,
                            input logic [19:0] tba, output int kind, output logic [31:0] pcnew);
      logic is_save;
      is_save = sv;
      pcnew = '0;
      if (m_err) begin
         kind = 3;
      end else if (!(of || uf)) begin
         kind = 0;
         m_cwp = is_save ? (m_cwp + 1) % 4 : (m_cwp + 4 - 1) % 4;
      end else if (!m_et) begin
         kind = 2;
         m_err = 1'b1;
      end else begin
         kind = 1;
         m_ps = m_s; m_s = 1'b1; m_et = 1'b0;
         m_cwp = (m_cwp + 1) % 4;
         m_tt = of ? 8'h05 : 8'h06;
         pcnew = {tba, m_tt, 4'h0};
      end
      if (!sv && !rs) kind = -1;
   endtask

   initial begin
      vt[0]  = '{0, 1,0,0,0, 32'h10,  32'h14,  20'h0,     0, 5'd1, 1,1,0, 32'h0};
      vt[1]  = '{0, 0,1,0,0, 32'h20,  32'h24,  20'h0,     0, 5'd0, 1,1,0, 32'h0};
      vt[2]  = '{0, 0,1,0,0, 32'h30,  32'h34,  20'h0,     0, 5'd3, 1,1,0, 32'h0};
      vt[3]  = '{0, 1,1,0,0, 32'h30,  32'h34,  20'h0,     0, 5'd0, 1,1,0, 32'h0};
      vt[4]  = '{0, 0,1,0,0, 32'h30,  32'h34,  20'h0,     0, 5'd3, 1,1,0, 32'h0};
      vt[5]  = '{0, 1,0,1,0, 32'h40,  32'h44,  20'h00001, 1, 5'd0, 0,1,1, 32'h00001050};
      vt[6]  = '{0, 0,1,0,1, 32'h50,  32'h54,  20'h00001, 2, 5'd0, 0,1,1, 32'h0};
      vt[7]  = '{0, 1,0,0,0, 32'h60,  32'h64,  20'h00001, 3, 5'd0, 0,1,1, 32'h0};
      vt[8]  = '{1, 0,1,0,1, 32'h100, 32'h104, 20'hABCDE, 1, 5'd1, 0,1,1, 32'hABCDE060};
      vt[9]  = '{1, 1,0,1,1, 32'h2000,32'h2004,20'h12345, 1, 5'd1, 0,1,1, 32'h12345050};
      vt[10] = '{0, 1,0,0,0, 32'h70,  32'h74,  20'h12345, 0, 5'd2, 0,1,1, 32'h0};
      vt[11] = '{0, 0,1,0,0, 32'h80,  32'h84,  20'h12345, 0, 5'd1, 0,1,1, 32'h0};

      // reset state
      tba_in = 20'h5A5A5;
      #12;
      check("rst_cwp", 32'(cwp), 32'd0);
      check("rst_et", 32'(psr_et), 32'd1);
      check("rst_s", 32'(psr_s), 32'd1);
      check("rst_ps", 32'(psr_ps), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(error_mode), 32'd0);
      check("rst_tg", 32'(tg_enable), 32'd0);
      check("rst_rfwe", 32'(rf_we), 32'd0);
      check("rst_pcload", 32'(pc_load), 32'd0);
      check("rst_tbr", tbr_out, 32'h5A5A5000);
      @(posedge Clk); #1;
      Clr = 1'b0;
      model_reset();

      // directed table
      foreach (vt[i]) begin
         if (vt[i].rst_first) do_reset();
         run_txn(vt[i].sv, vt[i].rs, vt[i].of, vt[i].uf, vt[i].pc, vt[i].npc, vt[i].tba,
                 vt[i].kind, vt[i].e_cwp, vt[i].e_et, vt[i].e_s, vt[i].e_ps, vt[i].e_pcnew);
      end

      // Clr during SAVE_PC aborts the trap entry immediately
      do_reset();
      save_req = 1'b1; overFlow = 1'b1; pc_in = 32'h900; npc_in = 32'h904; tba_in = 20'h00002;
      for (int c = 1; c <= 4; c++) begin
         @(posedge Clk); #1;
         save_req = 1'b0;
      end
      check("abort_in_save_pc", 32'({rf_we, rf_waddr}), 32'({1'b1, 5'd17}));
      Clr = 1'b1;
      #1;
      check("abort_cwp", 32'(cwp), 32'd0);
      check("abort_et", 32'(psr_et), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rfwe", 32'(rf_we), 32'd0);
      overFlow = 1'b0;
      @(posedge Clk); #1;
      Clr = 1'b0;
      model_reset();
      run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0, 32'hA4, 20'h0, 0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0);
      m_cwp = 1;

      // randomized transactions against the reference model
      for (int n = 0; n < 60; n++) begin
         logic sv, rs, of, uf;
         logic [31:0] pc, pcnew;
         logic [19:0] tba;
         int kind;
         if (m_err && $urandom_range(0, 1) == 0) do_reset();
         else if ($urandom_range(0, 15) == 0) do_reset();
         sv = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         if (!sv && !rs) rs = 1'b1;
         of = ($urandom_range(0, 5) == 0);
         uf = ($urandom_range(0, 5) == 0);
         pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
         tba = 20'($urandom);
         model_txn(sv, rs, of, uf, tba, kind, pcnew);
         run_txn(sv, rs, of, uf, pc, pc + 32'd4, tba, kind, 5'(m_cwp), m_et, m_s, m_ps, pcnew);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
